univ_shift_reg: RTL and testbench
=================================

// Module: univ_shift_reg
// PURPOSE
//   Parametrised universal shift register: WIDTH-bit storage with hold, shift,
//   rotate, arithmetic shift, parallel load and sync clear, selectable active
//   clock edge, and a saturating shift counter with done flag.
//   Successor to the single-bit edge-triggered DFF with async reset. Used as a
//   serializer/deserializer and general-purpose data register.
// PARAMETERS
//   WIDTH      8   data width, >= 2
//   RESET_VAL  0   value of q on rst (WIDTH bits)
//   NEG_EDGE   1   1: all state updates on falling clk; 0: on rising clk
// PORTS
//   clk      in   1                clock; active edge per NEG_EDGE
//   rst      in   1                asynchronous, active-high reset
//   en       in   1                op enable; 0 = hold regardless of mode
//   mode     in   3                operation select (see BEHAVIOUR)
//   d        in   WIDTH            parallel load data
//   sin_r    in   1                serial in, enters MSB on shift right
//   sin_l    in   1                serial in, enters LSB on shift left
//   q        out  WIDTH            register contents
//   sout_r   out  1                q[0] (bit leaving on shift right)
//   sout_l   out  1                q[WIDTH-1] (bit leaving on shift left)
//   cnt      out  $clog2(WIDTH+1)  shift/rotate ops since last load/clear
//   done     out  1                high while cnt == WIDTH
//   par      out  1                even parity of q (only with USR_PARITY_EN)
// BEHAVIOUR
//   - rst=1 (any time, no clock needed): q=RESET_VAL, cnt=0, done=0, par=^RESET_VAL.
//     Reset dominates en/mode. Release takes effect at the next active edge.
//   - All updates on the active edge only; latency 1 edge; outputs registered
//     except sout_r/sout_l (wired from q).
//   - en=0: q, cnt, done hold.
//   - en=1, mode:
//       000 HOLD    q unchanged, cnt unchanged
//       001 SHR     q <= {sin_r, q[W-1:1]}
//       010 SHL     q <= {q[W-2:0], sin_l}
//       011 ROR     q <= {q[0], q[W-1:1]}
//       100 ROL     q <= {q[W-2:0], q[W-1]}
//       101 LOAD    q <= d; cnt <= 0
//       110 CLR     q <= RESET_VAL; cnt <= 0 (synchronous)
//       111 ASR     q <= {q[W-1], q[W-1:1]}
//   - cnt increments on modes 001,010,011,100,111; saturates at WIDTH (no wrap).
//   - done registered: done <= (next cnt == WIDTH); LOAD/CLR clear it same edge.
//   - Rotate W times returns q to the pre-rotation value with done=1.
// CONFIGURATION
//   - `define USR_PARITY_EN: port par present, registered, updated on the same
//     edge as q; par == ^q at all times after each edge/reset.
//   - Without it: no par port, no parity logic; all else identical.
// STRUCTURE
//   - Package usr_pkg: mode localparams (USR_HOLD..USR_ASR), mode width (3).
//   - Sub-module usr_shift_cnt: saturating counter + done (inputs clk_i, rst,
//     inc, clr; param MAX=WIDTH).
//   - Internal clk_i = NEG_EDGE ? ~clk : clk; single always block for q.
// TESTING
//   - rst=1 mid-run with en=1, mode=SHR -> q=RESET_VAL, cnt=0, done=0
//     immediately, no clock edge required.
//   - W=8, LOAD d=8'hA5, then 8x SHR with sin_r=0 -> sout_r stream 1,0,1,0,0,1,0,1;
//     q=8'h00; cnt=8; done=1.
//   - LOAD 8'h81, ROL x8 -> q=8'h81; cnt saturates at 8; 9th ROL keeps cnt=8.
//   - LOAD 8'h80, ASR x3 -> q=8'hF0; then CLR -> q=RESET_VAL, cnt=0, done=0.
//   - en=0 with mode=SHL for 5 edges -> q, cnt unchanged; NEG_EDGE=1 -> no
//     change on rising edges, update on falling.
//   - USR_PARITY_EN: LOAD 8'h07 -> par=1; SHL sin_l=0 -> q=8'h0E, par=1.

Source files
------------

// File: rtl/usr_pkg.sv
// Shared mode encodings for the universal shift register.
// Optional parity output of the top is enabled by `define USR_PARITY_EN.
package usr_pkg;

   localparam int USR_MODE_W = 3;

   localparam logic [USR_MODE_W-1:0] USR_HOLD = 3'b000;
   localparam logic [USR_MODE_W-1:0] USR_SHR  = 3'b001;
   localparam logic [USR_MODE_W-1:0] USR_SHL  = 3'b010;
   localparam logic [USR_MODE_W-1:0] USR_ROR  = 3'b011;
   localparam logic [USR_MODE_W-1:0] USR_ROL  = 3'b100;
   localparam logic [USR_MODE_W-1:0] USR_LOAD = 3'b101;
   localparam logic [USR_MODE_W-1:0] USR_CLR  = 3'b110;
   localparam logic [USR_MODE_W-1:0] USR_ASR  = 3'b111;

endpackage

// File: rtl/usr_shift_cnt.sv
// Saturating shift counter with registered done flag (done high while count == MAX).
// clr has priority over inc; the count never wraps past MAX.
module usr_shift_cnt #(
   parameter int MAX = 8,
   parameter int CW  = $clog2(MAX + 1)
) (
   input  logic          clk_i,
   input  logic          rst,
   input  logic          inc,
   input  logic          clr,
   output logic [CW-1:0] cnt,
   output logic          done
);

   logic [CW-1:0] r_cnt;
   logic          r_done;
   logic [CW-1:0] w_next_cnt;

   // Next count: clear, saturating increment, or hold
   always_comb begin
      w_next_cnt = r_cnt;
      if (clr) begin
         w_next_cnt = '0;
      end else if (inc && (r_cnt != CW'(MAX))) begin
         w_next_cnt = r_cnt + CW'(1);
      end else begin
         w_next_cnt = r_cnt;
      end
   end

   // Count and done registers; done tracks the value the count is about to take
   always_ff @(posedge clk_i or posedge rst) begin
      if (rst) begin
         r_cnt  <= '0;
         r_done <= 1'b0;
      end else begin
         r_cnt  <= w_next_cnt;
         r_done <= (w_next_cnt == CW'(MAX));
      end
   end

   assign cnt  = r_cnt;
   assign done = r_done;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold/shift/rotate/arith-shift/load/clear with shift counter.
// `define USR_PARITY_EN adds a registered even-parity output par.
module univ_shift_reg
   import usr_pkg::*;
#(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   parameter bit               NEG_EDGE  = 1'b1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       en,
   input  logic [USR_MODE_W-1:0]      mode,
   input  logic [WIDTH-1:0]           d,
   input  logic                       sin_r,
   input  logic                       sin_l,
   output logic [WIDTH-1:0]           q,
   output logic                       sout_r,
   output logic                       sout_l,
   output logic [$clog2(WIDTH+1)-1:0] cnt,
   output logic                       done
`ifdef USR_PARITY_EN
   ,
   output logic                       par
`endif
);

   logic             w_clk_i;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] w_next_q;
   logic             w_inc;
   logic             w_clr;

   // Edge selection is done once here so every register below uses posedge
   assign w_clk_i = NEG_EDGE ? ~clk : clk;

   // Next-state data and counter controls for the selected operation
   always_comb begin
      w_next_q = r_q;
      w_inc    = 1'b0;
      w_clr    = 1'b0;
      if (en) begin
         case (mode)
            USR_HOLD: begin
               w_next_q = r_q;
            end
            USR_SHR: begin
               w_next_q = {sin_r, r_q[WIDTH-1:1]};
               w_inc    = 1'b1;
            end
            USR_SHL: begin
               w_next_q = {r_q[WIDTH-2:0], sin_l};
               w_inc    = 1'b1;
            end
            USR_ROR: begin
               w_next_q = {r_q[0], r_q[WIDTH-1:1]};
               w_inc    = 1'b1;
            end
            USR_ROL: begin
               w_next_q = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
               w_inc    = 1'b1;
            end
            USR_LOAD: begin
               w_next_q = d;
               w_clr    = 1'b1;
            end
            USR_CLR: begin
               w_next_q = RESET_VAL;
               w_clr    = 1'b1;
            end
            USR_ASR: begin
               w_next_q = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
               w_inc    = 1'b1;
            end
            default: begin
               w_next_q = r_q;
            end
         endcase
      end else begin
         w_next_q = r_q;
      end
   end

   // Data register
   always_ff @(posedge w_clk_i or posedge rst) begin
      if (rst) begin
         r_q <= RESET_VAL;
      end else begin
         r_q <= w_next_q;
      end
   end

   usr_shift_cnt #(
      .MAX (WIDTH)
   ) u_cnt (
      .clk_i (w_clk_i),
      .rst   (rst),
      .inc   (w_inc),
      .clr   (w_clr),
      .cnt   (cnt),
      .done  (done)
   );

`ifdef USR_PARITY_EN
   logic r_par;

   function automatic logic f_even_par(input logic [WIDTH-1:0] v);
      return ^v;
   endfunction

   // Parity is computed from next-state data so it lands on the same edge as q
   always_ff @(posedge w_clk_i or posedge rst) begin
      if (rst) begin
         r_par <= f_even_par(RESET_VAL);
      end else begin
         r_par <= f_even_par(w_next_q);
      end
   end

   assign par = r_par;
`endif

   assign q      = r_q;
   assign sout_r = r_q[0];
   assign sout_l = r_q[WIDTH-1];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Scoreboard bench for univ_shift_reg (WIDTH=8, RESET_VAL=0, falling-edge updates).
// Checks par as well when compiled with `define USR_PARITY_EN.
module tb_univ_shift_reg;
   import usr_pkg::*;

   typedef struct packed {
      logic [7:0] q;
      logic [3:0] cnt;
      logic       done;
   } exp_t;

   typedef struct {
      logic       en;
      logic [2:0] mode;
      logic [7:0] d;
      logic       sr;
      logic       sl;
      exp_t       e;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic [2:0] mode = 3'b000;
   logic [7:0] d = 8'h00;
   logic       sin_r = 1'b0;
   logic       sin_l = 1'b0;
   logic [7:0] q;
   logic       sout_r;
   logic       sout_l;
   logic [3:0] cnt;
   logic       done;
`ifdef USR_PARITY_EN
   logic       par;
`endif

   int   checks = 0;
   int   failures = 0;
   exp_t sb_q[$];
   vec_t vecs[$];
   exp_t last_e;
   bit   have_last = 1'b0;
   event ev_async;

   univ_shift_reg #(.WIDTH(8), .RESET_VAL(8'h00), .NEG_EDGE(1'b1)) dut (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .mode   (mode),
      .d      (d),
      .sin_r  (sin_r),
      .sin_l  (sin_l),
      .q      (q),
      .sout_r (sout_r),
      .sout_l (sout_l),
      .cnt    (cnt),
      .done   (done)
`ifdef USR_PARITY_EN
      ,
      .par    (par)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s t=%0t actual=%0h expected=%0h", name, $time, act, exp);
      end
   endtask

   task automatic add(input logic e_n, input logic [2:0] m, input logic [7:0] dv,
                      input logic sr, input logic sl,
                      input logic [7:0] eq, input logic [3:0] ec, input logic ed);
      vec_t v;
      v.en = e_n; v.mode = m; v.d = dv; v.sr = sr; v.sl = sl;
      v.e.q = eq; v.e.cnt = ec; v.e.done = ed;
      vecs.push_back(v);
   endtask

   // Monitor: pop and compare after every update edge or async-reset notification
   initial begin
      exp_t e;
      forever begin
         @(negedge clk or ev_async);
         #1;
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("q", 32'(q), 32'(e.q));
            chk("cnt", 32'(cnt), 32'(e.cnt));
            chk("done", 32'(done), 32'(e.done));
            chk("sout_r", 32'(sout_r), 32'(e.q[0]));
            chk("sout_l", 32'(sout_l), 32'(e.q[7]));
`ifdef USR_PARITY_EN
            chk("par", 32'(par), 32'(^e.q));
`endif
            last_e = e;
            have_last = 1'b1;
         end
      end
   end

   // Rising edges must never change state
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (have_last) begin
            chk("rise_q", 32'(q), 32'(last_e.q));
            chk("rise_cnt", 32'(cnt), 32'(last_e.cnt));
         end
      end
   end

   initial begin
      exp_t rexp;
      rexp = '{q: 8'h00, cnt: 4'd0, done: 1'b0};

      // Load then 8 shifts right: sout_r stream 1,0,1,0,0,1,0,1
      add(1'b1, USR_LOAD, 8'hA5, 1'b0, 1'b0, 8'hA5, 4'd0, 1'b0);
      add(1'b1, USR_SHR, 8'h00, 1'b0, 1'b0, 8'h52, 4'd1, 1'b0);
      add(1'b1, USR_SHR, 8'h00, 1'b0, 1'b0, 8'h29, 4'd2, 1'b0);
      add(1'b1, USR_SHR, 8'h00, 1'b0, 1'b0, 8'h14, 4'd3, 1'b0);
      add(1'b1, USR_SHR, 8'h00, 1'b0, 1'b0, 8'h0A, 4'd4, 1'b0);
      add(1'b1, USR_SHR, 8'h00, 1'b0, 1'b0, 8'h05, 4'd5, 1'b0);
      add(1'b1, USR_SHR, 8'h00, 1'b0, 1'b0, 8'h02, 4'd6, 1'b0);
      add(1'b1, USR_SHR, 8'h00, 1'b0, 1'b0, 8'h01, 4'd7, 1'b0);
      add(1'b1, USR_SHR, 8'h00, 1'b0, 1'b0, 8'h00, 4'd8, 1'b1);
      add(1'b1, USR_SHR, 8'h00, 1'b1, 1'b0, 8'h80, 4'd8, 1'b1);
      // Rotate left 8 times returns the value; 9th saturates count
      add(1'b1, USR_LOAD, 8'h81, 1'b0, 1'b0, 8'h81, 4'd0, 1'b0);
      add(1'b1, USR_ROL, 8'h00, 1'b0, 1'b0, 8'h03, 4'd1, 1'b0);
      add(1'b1, USR_ROL, 8'h00, 1'b0, 1'b0, 8'h06, 4'd2, 1'b0);
      add(1'b1, USR_ROL, 8'h00, 1'b0, 1'b0, 8'h0C, 4'd3, 1'b0);
      add(1'b1, USR_ROL, 8'h00, 1'b0, 1'b0, 8'h18, 4'd4, 1'b0);
      add(1'b1, USR_ROL, 8'h00, 1'b0, 1'b0, 8'h30, 4'd5, 1'b0);
      add(1'b1, USR_ROL, 8'h00, 1'b0, 1'b0, 8'h60, 4'd6, 1'b0);
      add(1'b1, USR_ROL, 8'h00, 1'b0, 1'b0, 8'hC0, 4'd7, 1'b0);
      add(1'b1, USR_ROL, 8'h00, 1'b0, 1'b0, 8'h81, 4'd8, 1'b1);
      add(1'b1, USR_ROL, 8'h00, 1'b0, 1'b0, 8'h03, 4'd8, 1'b1);
      // Arithmetic shift then synchronous clear
      add(1'b1, USR_LOAD, 8'h80, 1'b0, 1'b0, 8'h80, 4'd0, 1'b0);
      add(1'b1, USR_ASR, 8'h00, 1'b0, 1'b0, 8'hC0, 4'd1, 1'b0);
      add(1'b1, USR_ASR, 8'h00, 1'b0, 1'b0, 8'hE0, 4'd2, 1'b0);
      add(1'b1, USR_ASR, 8'h00, 1'b0, 1'b0, 8'hF0, 4'd3, 1'b0);
      add(1'b1, USR_CLR, 8'hFF, 1'b1, 1'b1, 8'h00, 4'd0, 1'b0);
      // Parity pattern, then en=0 hold with mode SHL for 5 edges
      add(1'b1, USR_LOAD, 8'h07, 1'b0, 1'b0, 8'h07, 4'd0, 1'b0);
      add(1'b1, USR_SHL, 8'h00, 1'b0, 1'b0, 8'h0E, 4'd1, 1'b0);
      for (int i = 0; i < 5; i++) add(1'b0, USR_SHL, 8'hFF, 1'b1, 1'b1, 8'h0E, 4'd1, 1'b0);
      add(1'b1, USR_SHL, 8'h00, 1'b0, 1'b1, 8'h1D, 4'd2, 1'b0);
      add(1'b1, USR_ROR, 8'h00, 1'b0, 1'b0, 8'h8E, 4'd3, 1'b0);
      add(1'b1, USR_HOLD, 8'hFF, 1'b1, 1'b1, 8'h8E, 4'd3, 1'b0);
      add(1'b1, USR_SHR, 8'h00, 1'b1, 1'b0, 8'hC7, 4'd4, 1'b0);

      #2;
      sb_q.push_back(rexp);
      -> ev_async;
      @(posedge clk);
      rst = 1'b0;
      foreach (vecs[i]) begin
         en = vecs[i].en; mode = vecs[i].mode; d = vecs[i].d;
         sin_r = vecs[i].sr; sin_l = vecs[i].sl;
         sb_q.push_back(vecs[i].e);
         @(posedge clk);
      end

      // Async reset mid-run while shifting: must act without a clock edge
      en = 1'b1; mode = USR_SHR; sin_r = 1'b1;
      #2;
      rst = 1'b1;
      sb_q.push_back(rexp);
      -> ev_async;
      @(posedge clk);
      rst = 1'b0;
      sb_q.push_back('{q: 8'h80, cnt: 4'd1, done: 1'b0});
      @(posedge clk);
      en = 1'b0;

      repeat (3) @(negedge clk);
      #2;
      chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
